// File: rtl/lcd_ctrl.sv
// Sequencer for an HD44780-type character LCD in 4-bit mode: self-running power-up init,
// CPU byte writes split into two E-strobed nibbles, and bus stall while the display is busy.
module lcd_ctrl #(
    parameter int T_POR   = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_SU    = 2,
    parameter int T_PW    = 12,
    parameter int T_H     = 1,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [3:0]  lcd_d
);

    localparam int CW = 20;

    // Steps 0..3 are the four init nibbles; 4/5 are the high/low nibble of a CPU byte.
    localparam logic [2:0] STEP_LAST_INIT = 3'd3;
    localparam logic [2:0] STEP_HI        = 3'd4;
    localparam logic [2:0] STEP_LO        = 3'd5;

    typedef enum logic [2:0] {
        S_POR,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t          r_state, w_state_next;
    logic [2:0]      r_step, w_step_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [7:0]      r_byte, w_byte_next;
    logic            r_rs_sel, w_rs_sel_next;
    logic            r_busy;
    logic            r_lcd_e;
    logic            r_lcd_rs;
    logic [3:0]      r_lcd_d;

    logic            w_done;
    logic            w_long;
    logic [CW-1:0]   w_wait_len;
    logic [3:0]      w_nib;
    logic            w_nib_rs;
    logic            w_unused;

    function automatic logic [CW-1:0] cyc_m1(input int n);
        return CW'(n - 1);
    endfunction

    assign w_unused = ^data_in[31:8];
    assign w_done   = (r_cnt == '0);
    assign w_long   = ~r_rs_sel && (r_byte inside {8'h01, 8'h02, 8'h03});

    always_comb begin
        w_wait_len = cyc_m1(T_CMD);
        case (r_step)
            3'd0:    w_wait_len = cyc_m1(T_INIT1);
            3'd1:    w_wait_len = cyc_m1(T_INIT2);
            3'd2,
            3'd3:    w_wait_len = cyc_m1(T_CMD);
            STEP_HI: w_wait_len = cyc_m1(T_NIB);
            default: w_wait_len = w_long ? cyc_m1(T_LONG) : cyc_m1(T_CMD);
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_step_next   = r_step;
        w_cnt_next    = r_cnt;
        w_byte_next   = r_byte;
        w_rs_sel_next = r_rs_sel;
        case (r_state)
            S_POR: begin
                if (w_done) begin
                    w_state_next = S_SETUP;
                    w_step_next  = 3'd0;
                    w_cnt_next   = cyc_m1(T_SU);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_SETUP: begin
                if (w_done) begin
                    w_state_next = S_PULSE;
                    w_cnt_next   = cyc_m1(T_PW);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (w_done) begin
                    w_state_next = S_HOLD;
                    w_cnt_next   = cyc_m1(T_H);
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (w_done) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = w_wait_len;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (w_done) begin
                    if (r_step == STEP_LAST_INIT || r_step == STEP_LO) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_SETUP;
                        w_step_next  = r_step + 3'd1;
                        w_cnt_next   = cyc_m1(T_SU);
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_IDLE: begin
                if (en && wr && !r_busy) begin
                    w_state_next  = S_SETUP;
                    w_step_next   = STEP_HI;
                    w_byte_next   = data_in[7:0];
                    w_rs_sel_next = addr;
                    w_cnt_next    = cyc_m1(T_SU);
                end
            end
            default: begin
                w_state_next = S_POR;
                w_cnt_next   = cyc_m1(T_POR);
            end
        endcase
    end

    // Nibble presented on the pins when the next step's SETUP phase begins.
    always_comb begin
        w_nib    = 4'h3;
        w_nib_rs = 1'b0;
        case (w_step_next)
            3'd3:    w_nib = 4'h2;
            STEP_HI: w_nib = w_byte_next[7:4];
            STEP_LO: w_nib = w_byte_next[3:0];
            default: w_nib = 4'h3;
        endcase
        if (w_step_next >= STEP_HI) begin
            w_nib_rs = w_rs_sel_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_POR;
            r_step   <= 3'd0;
            r_cnt    <= cyc_m1(T_POR);
            r_byte   <= 8'h00;
            r_rs_sel <= 1'b0;
            r_busy   <= 1'b1;
            r_lcd_e  <= 1'b0;
            r_lcd_rs <= 1'b0;
            r_lcd_d  <= 4'h0;
        end else begin
            r_state  <= w_state_next;
            r_step   <= w_step_next;
            r_cnt    <= w_cnt_next;
            r_byte   <= w_byte_next;
            r_rs_sel <= w_rs_sel_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_lcd_e  <= (w_state_next == S_PULSE);
            if (w_state_next == S_SETUP && r_state != S_SETUP) begin
                r_lcd_d  <= w_nib;
                r_lcd_rs <= w_nib_rs;
            end
        end
    end

    assign data_out = {31'b0, r_busy};
    assign wt       = en & wr & r_busy;
    assign lcd_e    = r_lcd_e;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_d    = r_lcd_d;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed and random byte writes with expected E-pulse times,
// nibbles and busy windows computed from the timing rules with plain arithmetic.
module tb_lcd_ctrl;

    localparam int T_POR   = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 5;
    localparam int T_SU    = 2;
    localparam int T_PW    = 3;
    localparam int T_H     = 1;
    localparam int T_NIB   = 4;
    localparam int T_CMD   = 8;
    localparam int T_LONG  = 30;
    localparam int BOUND   = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        wt;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [3:0]  lcd_d;

    lcd_ctrl #(
        .T_POR(T_POR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SU(T_SU), .T_PW(T_PW),
        .T_H(T_H), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_LONG(T_LONG)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .wt(wt), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] d;
        logic       rs;
    } rise_t;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    idle_at = 0;
    rise_t rise_q[$];
    int    fall_q[$];
    int    idle_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pin monitor: logs E edges and busy falls, checks pins stay put while E is high and in hold.
    initial begin
        logic       prev_e = 1'b0;
        logic       prev_busy = 1'b0;
        logic [3:0] held_d = 4'h0;
        logic       held_rs = 1'b0;
        forever begin
            @(negedge clk);
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                rise_q.push_back('{cyc, lcd_d, lcd_rs});
                held_d  = lcd_d;
                held_rs = lcd_rs;
            end
            if (lcd_e === 1'b0 && prev_e === 1'b1) fall_q.push_back(cyc);
            if (!reset && (lcd_e === 1'b1 || prev_e === 1'b1)) begin
                chk("d_stable", lcd_d, held_d);
                chk("rs_stable", lcd_rs, held_rs);
                chk("rw_zero", lcd_rw, 1'b0);
            end
            if (prev_busy === 1'b1 && data_out[0] === 1'b0) idle_q.push_back(cyc);
            prev_e    = lcd_e;
            prev_busy = data_out[0];
        end
    end

    task automatic expect_pulse(input string tag, input int t, input logic [3:0] d,
                                input logic rs, input int width);
        int    guard = 0;
        rise_t r;
        int    f;
        while (rise_q.size() == 0 && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (rise_q.size() == 0) begin
            chk({tag, "_rise_timeout"}, 32'd0, 32'd1);
            return;
        end
        r = rise_q.pop_front();
        chk({tag, "_t"}, r.t, t);
        chk({tag, "_d"}, r.d, d);
        chk({tag, "_rs"}, r.rs, rs);
        guard = 0;
        while (fall_q.size() == 0 && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (fall_q.size() == 0) begin
            chk({tag, "_fall_timeout"}, 32'd0, 32'd1);
            return;
        end
        f = fall_q.pop_front();
        chk({tag, "_width"}, f - r.t, width);
    endtask

    task automatic expect_idle(input string tag, input int t);
        int guard = 0;
        while (idle_q.size() == 0 && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (idle_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk(tag, idle_q.pop_front(), t);
    endtask

    task automatic read_chk(input string tag);
        @(negedge clk);
        en   = 1'b1;
        wr   = 1'b0;
        addr = 1'($urandom);
        #1;
        chk({tag, "_data"}, data_out, {31'b0, (cyc < idle_at)});
        chk({tag, "_wt"}, wt, 1'b0);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Holds the write until wt drops; acc is the edge that accepts it.
    task automatic do_write(input logic a_in, input logic [7:0] b, output int acc,
                            output int stalls);
        int guard = 0;
        stalls = 0;
        @(negedge clk);
        en      = 1'b1;
        wr      = 1'b1;
        addr    = a_in;
        data_in = {24'($urandom), b};
        #1;
        while (wt === 1'b1 && guard < BOUND) begin
            @(negedge clk);
            #1;
            stalls++;
            guard++;
        end
        if (wt !== 1'b0) chk("write_timeout", wt, 1'b0);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wr = 1'b0;
    endtask

    function automatic int init_done(input int c);
        int r0, r1, r2, r3;
        r0 = c + T_POR + T_SU;
        r1 = r0 + T_PW + T_H + T_INIT1 + T_SU;
        r2 = r1 + T_PW + T_H + T_INIT2 + T_SU;
        r3 = r2 + T_PW + T_H + T_CMD + T_SU;
        return r3 + T_PW + T_H + T_CMD;
    endfunction

    task automatic expect_init(input string tag, input int c);
        int r;
        r = c + T_POR + T_SU;
        expect_pulse({tag, "_n0"}, r, 4'h3, 1'b0, T_PW);
        r = r + T_PW + T_H + T_INIT1 + T_SU;
        expect_pulse({tag, "_n1"}, r, 4'h3, 1'b0, T_PW);
        r = r + T_PW + T_H + T_INIT2 + T_SU;
        expect_pulse({tag, "_n2"}, r, 4'h3, 1'b0, T_PW);
        r = r + T_PW + T_H + T_CMD + T_SU;
        expect_pulse({tag, "_n3"}, r, 4'h2, 1'b0, T_PW);
        expect_idle({tag, "_idle"}, init_done(c));
        $display("txn %s init_sequence start=%0d done=%0d", tag, c, init_done(c));
    endtask

    function automatic int byte_done(input int acc, input logic a_in, input logic [7:0] b);
        int lo;
        lo = acc + T_SU + T_PW + T_H + T_NIB + T_SU;
        return lo + T_PW + T_H + ((!a_in && b >= 8'h01 && b <= 8'h03) ? T_LONG : T_CMD);
    endfunction

    task automatic expect_byte(input string tag, input int acc, input logic a_in,
                               input logic [7:0] b);
        int hi;
        hi = acc + T_SU;
        expect_pulse({tag, "_hi"}, hi, b[7:4], a_in, T_PW);
        expect_pulse({tag, "_lo"}, hi + T_PW + T_H + T_NIB + T_SU, b[3:0], a_in, T_PW);
        expect_idle({tag, "_idle"}, byte_done(acc, a_in, b));
        $display("txn %s addr=%0d byte=%02h accept=%0d", tag, a_in, b, acc);
    endtask

    task automatic send(input string tag, input logic a_in, input logic [7:0] b);
        int acc, st;
        do_write(a_in, b, acc, st);
        chk({tag, "_stall"}, st, 0);
        idle_at = byte_done(acc, a_in, b);
        read_chk({tag, "_rd"});
        expect_byte(tag, acc, a_in, b);
    endtask

    task automatic apply_reset(input string tag, output int c);
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        wr    = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy"}, data_out, 32'h1);
        chk({tag, "_e"}, lcd_e, 1'b0);
        chk({tag, "_d"}, lcd_d, 4'h0);
        chk({tag, "_rs"}, lcd_rs, 1'b0);
        chk({tag, "_rw"}, lcd_rw, 1'b0);
        c       = cyc;
        reset   = 1'b0;
        idle_at = init_done(c);
    endtask

    initial begin
        int         c, a1, a2, s1, s2, acc, st, guard;
        logic [7:0] b;
        logic       a_in;

        // Power-up init, with a status read part-way through.
        apply_reset("rst0", c);
        repeat (5) @(negedge clk);
        read_chk("rd_init");
        expect_init("init0", c);

        // Directed bytes: data, long command, normal command.
        send("data41", 1'b1, 8'h41);
        send("cmd01", 1'b0, 8'h01);
        send("cmd80", 1'b0, 8'h80);

        // Back-to-back writes: second one stalls until the first finishes.
        do_write(1'b1, 8'h48, a1, s1);
        idle_at = byte_done(a1, 1'b1, 8'h48);
        do_write(1'b1, 8'h49, a2, s2);
        chk("b2b_accept", a2, idle_at + 1);
        chk("b2b_stalls", s2, idle_at - a1);
        expect_byte("b2b_48", a1, 1'b1, 8'h48);
        expect_byte("b2b_49", a2, 1'b1, 8'h49);
        idle_at = byte_done(a2, 1'b1, 8'h49);

        // Random bytes, biased towards the clear/home commands.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) read_chk("rd_gap");
            a_in = 1'($urandom);
            b    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send("rnd", a_in, b);
        end

        // A write issued during init waits for init to finish.
        apply_reset("rst1", c);
        repeat (3) @(negedge clk);
        read_chk("rd_init1");
        do_write(1'b1, 8'h5C, acc, st);
        chk("init_wr_accept", acc, init_done(c) + 1);
        expect_init("init1", c);
        expect_byte("init_wr", acc, 1'b1, 8'h5C);
        idle_at = byte_done(acc, 1'b1, 8'h5C);

        // Reset during the high-nibble pulse aborts the byte.
        do_write(1'b1, 8'h5A, acc, st);
        guard = 0;
        while (lcd_e !== 1'b1 && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_seen_e", lcd_e, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_e_low", lcd_e, 1'b0);
        expect_pulse("abort_hi", acc + T_SU, 4'h5, 1'b1, 1);
        repeat (2) @(negedge clk);
        c       = cyc;
        reset   = 1'b0;
        idle_at = init_done(c);
        expect_init("init2", c);
        repeat (40) @(negedge clk);
        chk("no_extra_rise", rise_q.size(), 0);
        chk("no_extra_fall", fall_q.size(), 0);
        chk("no_extra_idle", idle_q.size(), 0);
        read_chk("rd_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
